// File: rtl/pulse_seq_multi.sv
// rtl/pulse_seq_multi.sv - multi-channel periodic pulse sequencer; PULSE_SEQ_CPMG_EN adds a CPMG echo train on pulse[0]
module pulse_seq_multi #(
    parameter int NCH    = 4,
    parameter int CW     = 32,
    parameter int SYNC_W = 4
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [7:0]     cmd_addr,
    input  logic [CW-1:0]  cmd_data,
    input  logic           run,
    output logic           sync,
    output logic [NCH-1:0] pulse,
    output logic           busy,
    output logic           seq_done
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]  delay_s [NCH];
    logic [CW-1:0]  width_s [NCH];
    logic [NCH-1:0] en_s;
    logic [CW-1:0]  period_s, shots_s;
    logic [CW-1:0]  delay_a [NCH];
    logic [CW-1:0]  width_a [NCH];
    logic [NCH-1:0] en_a;
    logic [CW-1:0]  period_a, shots_a;

    logic [CW-1:0]  cnt, shot_cnt, p_eff;
    logic           wait_low, last_cnt, shot_hit, load_act;
    logic [NCH-1:0] pulse_nxt;
    logic           sync_nxt, done_nxt;

    assign cmd_ready = !resetn;
    assign busy      = (state == S_RUN);
    assign p_eff     = (period_a < CW'(2)) ? CW'(2) : period_a;
    assign last_cnt  = (cnt == p_eff - CW'(1));
    assign shot_hit  = (shots_a != '0) && (shot_cnt + CW'(1) == shots_a);
    // Active registers follow the shadows whenever idle and at each period boundary.
    assign load_act  = (state == S_IDLE) || last_cnt;

`ifdef PULSE_SEQ_CPMG_EN
    logic [CW-1:0] cpmg_n_s, cpmg_sp_s, cpmg_n_a;
    logic [CW:0]   echo_next;
    logic [CW-1:0] echo_last, echo_k, echo_base;
    logic          echo_hit, echo_on;

    // Echoes share one length, so the most recently started echo always ends last.
    assign echo_hit  = (state == S_RUN) && (echo_k < cpmg_n_a) && ({1'b0, cnt} == echo_next);
    assign echo_base = echo_hit ? cnt : echo_last;
    assign echo_on   = (echo_hit || echo_k != '0)
                     && ({2'b0, cnt} < ({2'b0, echo_base} + {1'b0, width_a[0], 1'b0}));

    always_ff @(posedge clk) begin
        if (resetn) begin
            cpmg_n_s  <= '0;
            cpmg_sp_s <= '0;
            cpmg_n_a  <= '0;
            echo_next <= '0;
            echo_last <= '0;
            echo_k    <= '0;
        end else begin
            if (cmd_valid && cmd_addr == 8'hF1) cpmg_n_s  <= cmd_data;
            if (cmd_valid && cmd_addr == 8'hF2) cpmg_sp_s <= cmd_data;
            if (load_act) begin
                cpmg_n_a  <= cpmg_n_s;
                echo_next <= {1'b0, delay_s[0]} + {1'b0, cpmg_sp_s};
                echo_last <= '0;
                echo_k    <= '0;
            end else if (echo_hit) begin
                echo_next <= echo_next + {1'b0, cpmg_sp_s};
                echo_last <= cnt;
                echo_k    <= echo_k + CW'(1);
            end
        end
    end
`else
    logic echo_on;
    assign echo_on = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (resetn) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (run && !wait_low) state_nxt = S_RUN;
            S_RUN:   if (last_cnt && (!run || shot_hit)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pulse_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            pulse_nxt[i] = (state == S_RUN) && en_a[i] && (cnt >= delay_a[i])
                         && ({1'b0, cnt} < ({1'b0, delay_a[i]} + {1'b0, width_a[i]}));
        end
        pulse_nxt[0] = pulse_nxt[0] | ((state == S_RUN) && echo_on);
        sync_nxt     = (state == S_RUN) && (cnt < CW'(SYNC_W));
        done_nxt     = (state == S_RUN) && last_cnt && shot_hit;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            pulse    <= '0;
            sync     <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            pulse    <= pulse_nxt;
            sync     <= sync_nxt;
            seq_done <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int i = 0; i < NCH; i++) begin
                delay_s[i] <= '0;
                width_s[i] <= '0;
                delay_a[i] <= '0;
                width_a[i] <= '0;
            end
            en_s     <= '0;
            en_a     <= '0;
            period_s <= '0;
            shots_s  <= '0;
            period_a <= '0;
            shots_a  <= '0;
            cnt      <= '0;
            shot_cnt <= '0;
            wait_low <= 1'b0;
        end else begin
            if (cmd_valid) begin
                if (cmd_addr == 8'hF0) period_s <= cmd_data;
                if (cmd_addr == 8'hF3) shots_s  <= cmd_data;
                for (int i = 0; i < NCH; i++) begin
                    if (cmd_addr[7:4] == 4'(i)) begin
                        if (cmd_addr[3:0] == 4'h0) delay_s[i] <= cmd_data;
                        if (cmd_addr[3:0] == 4'h1) width_s[i] <= cmd_data;
                        if (cmd_addr[3:0] == 4'h2) en_s[i]    <= cmd_data[0];
                    end
                end
            end
            if (load_act) begin
                delay_a  <= delay_s;
                width_a  <= width_s;
                en_a     <= en_s;
                period_a <= period_s;
                shots_a  <= shots_s;
            end
            cnt      <= (state == S_RUN && !last_cnt) ? cnt + CW'(1) : '0;
            shot_cnt <= (state == S_IDLE) ? '0 : (last_cnt ? shot_cnt + CW'(1) : shot_cnt);
            if (done_nxt)  wait_low <= 1'b1;
            else if (!run) wait_low <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pulse_seq_multi.sv
// tb/tb_pulse_seq_multi.sv - self-checking bench for pulse_seq_multi against a cycle-level behavioural model
module tb_pulse_seq_multi;
    localparam int NCH = 4;
    localparam int CW = 32;
    localparam int SYNC_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [CW-1:0] cmd_data = '0;
    logic run = 1'b0;
    logic cmd_ready, sync, busy, seq_done;
    logic [NCH-1:0] pulse;

    always #5 clk = ~clk;

    pulse_seq_multi #(.NCH(NCH), .CW(CW), .SYNC_W(SYNC_W)) dut (
        .clk(clk), .resetn(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .run(run), .sync(sync),
        .pulse(pulse), .busy(busy), .seq_done(seq_done)
    );

    int n_tests = 0;
    int n_fail = 0;

    longint sh_d[NCH], sh_w[NCH], act_d[NCH], act_w[NCH];
    bit     sh_e[NCH], act_e[NCH];
    longint sh_p, sh_n, sh_s, sh_shots, act_p, act_n, act_s, act_shots;
    bit     m_run, m_block;
    longint m_cnt, m_periods;
    logic [NCH-1:0] e_pulse;
    logic e_sync, e_done;
    int c_p0, c_p1, c_p2, c_p3, c_sync, c_busy, c_done, c_any;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected pulse vector for period position c, straight from the window rules.
    function automatic logic [NCH-1:0] exp_pulse(input longint c, input longint per);
        logic [NCH-1:0] r;
        longint s;
        r = '0;
        for (int i = 0; i < NCH; i++)
            if (act_e[i] && c >= act_d[i] && c < act_d[i] + act_w[i] && c < per) r[i] = 1'b1;
`ifdef PULSE_SEQ_CPMG_EN
        for (longint k = 1; k <= act_n; k++) begin
            s = act_d[0] + k * act_s;
            if (c >= s && c < s + 2 * act_w[0]) r[0] = 1'b1;
            if (act_s == 0 || s > c) break;
        end
`endif
        return r;
    endfunction

    task automatic load_active();
        act_d = sh_d; act_w = sh_w; act_e = sh_e;
        act_p = sh_p; act_n = sh_n; act_s = sh_s; act_shots = sh_shots;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NCH; i++) begin
            sh_d[i] = 0; sh_w[i] = 0; sh_e[i] = 0;
        end
        sh_p = 0; sh_n = 0; sh_s = 0; sh_shots = 0;
        load_active();
        m_run = 0; m_block = 0; m_cnt = 0; m_periods = 0;
        e_pulse = '0; e_sync = 0; e_done = 0;
    endtask

    task automatic apply_write(input logic [7:0] a, input logic [CW-1:0] d);
        int ch;
        ch = int'(a[7:4]);
        if (ch == 15) begin
            case (a[3:0])
                4'h0: sh_p = longint'(d);
                4'h1: sh_n = longint'(d);
                4'h2: sh_s = longint'(d);
                4'h3: sh_shots = longint'(d);
                default: ;
            endcase
        end else if (ch < NCH) begin
            case (a[3:0])
                4'h0: sh_d[ch] = longint'(d);
                4'h1: sh_w[ch] = longint'(d);
                4'h2: sh_e[ch] = d[0];
                default: ;
            endcase
        end
    endtask

    // One clock edge of the reference: outputs from the pre-edge position, then state update.
    task automatic model_step();
        longint per;
        bit fin;
        if (rst) begin
            clear_model();
            return;
        end
        per = (act_p < 2) ? 2 : act_p;
        e_done = 0;
        fin = 0;
        e_pulse = m_run ? exp_pulse(m_cnt, per) : '0;
        e_sync = m_run && (m_cnt < SYNC_W);
        if (m_run) begin
            if (m_cnt == per - 1) begin
                m_periods++;
                fin = (act_shots != 0) && (m_periods == act_shots);
                load_active();
                m_cnt = 0;
                if (!run || fin) m_run = 0;
                e_done = fin;
            end else begin
                m_cnt++;
            end
        end else begin
            load_active();
            m_periods = 0;
            if (run && !m_block) begin
                m_run = 1;
                m_cnt = 0;
            end
        end
        if (fin) m_block = 1;
        else if (!run) m_block = 0;
        if (cmd_valid) apply_write(cmd_addr, cmd_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pulse", pulse, e_pulse);
        chk("sync", sync, e_sync);
        chk("busy", busy, m_run);
        chk("seq_done", seq_done, e_done);
        chk("cmd_ready", cmd_ready, !rst);
        c_p0 += int'(pulse[0]); c_p1 += int'(pulse[1]);
        c_p2 += int'(pulse[2]); c_p3 += int'(pulse[3]);
        c_sync += int'(sync); c_busy += int'(busy);
        c_done += int'(seq_done); c_any += int'(pulse != '0);
    endtask

    task automatic clr();
        c_p0 = 0; c_p1 = 0; c_p2 = 0; c_p3 = 0;
        c_sync = 0; c_busy = 0; c_done = 0; c_any = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [CW-1:0] d);
        cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_cnt(input longint t, input int max);
        int k;
        k = 0;
        while (!(m_run && m_cnt == t) && k < max) begin
            tick();
            k++;
        end
        chk("wait_cnt", 64'(m_run && m_cnt == t), 64'd1);
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while (busy && k < max) begin
            tick();
            k++;
        end
        chk("wait_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int len;
        clear_model();
        clr();
        cmd_valid = 1'b1; cmd_addr = 8'hF0; cmd_data = 32'd7;
        repeat (3) tick();
        cmd_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Unmapped addresses must not land anywhere.
        wr(8'h40, 32'd55); wr(8'h03, 32'd77); wr(8'hF4, 32'd9);

        wr(8'hF0, 32'd100); wr(8'h00, 32'd10); wr(8'h01, 32'd5); wr(8'h02, 32'd1);
        run = 1'b1; clr();
        repeat (200) tick();
        chk("basic_p0_count", c_p0, 10);
        chk("basic_sync_count", c_sync, 8);
        run = 1'b0;
        wait_idle(300);

        wr(8'hF3, 32'd3);
        run = 1'b1; clr();
        repeat (400) tick();
        chk("shots_done_count", c_done, 1);
        chk("shots_busy_cycles", c_busy, 300);
        chk("shots_p0_count", c_p0, 15);
        chk("shots_no_restart", busy, 1'b0);
        run = 1'b0; tick();
        run = 1'b1; tick();
        chk("shots_restart", busy, 1'b1);
        run = 1'b0;
        wait_idle(300);
        wr(8'hF3, 32'd0);

        wr(8'h10, 32'd30); wr(8'h11, 32'd5); wr(8'h12, 32'd1);
        run = 1'b1;
        wait_cnt(50, 300);
        clr();
        wr(8'h11, 32'd20);
        repeat (100) tick();
        chk("width_change_p1", c_p1, 20);
        run = 1'b0;
        wait_idle(300);

        wr(8'h20, 32'd90); wr(8'h21, 32'd20); wr(8'h22, 32'd1);
        wr(8'h30, 32'd5); wr(8'h31, 32'd0); wr(8'h32, 32'd1);
        run = 1'b1; clr();
        repeat (201) tick();
        chk("late_delay_p2", c_p2, 20);
        chk("zero_width_p3", c_p3, 0);
        run = 1'b0;
        wait_idle(300);

        wr(8'hF3, 32'd2);
        run = 1'b1;
        wait_cnt(40, 300);
        clr();
        rst = 1'b1;
        tick();
        chk("rst_pulse", pulse, '0);
        chk("rst_sync", sync, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", seq_done, 1'b0);
        rst = 1'b0; run = 1'b0;
        tick();
        run = 1'b1;
        repeat (50) tick();
        chk("rst_regs_no_pulse", c_any, 0);
        chk("rst_no_seq_done", c_done, 0);
        run = 1'b0;
        wait_idle(50);

        wr(8'hF0, 32'd100); wr(8'h00, 32'd10); wr(8'h01, 32'd4); wr(8'h02, 32'd1);
        wr(8'hF1, 32'd2); wr(8'hF2, 32'd20);
        run = 1'b1; clr();
        repeat (101) tick();
`ifdef PULSE_SEQ_CPMG_EN
        chk("cpmg_p0_count", c_p0, 20);
`else
        chk("cpmg_off_p0_count", c_p0, 4);
`endif
        run = 1'b0;
        wait_idle(300);

        for (int it = 0; it < 8; it++) begin
            wr(8'hF0, $urandom_range(0, 40));
            for (int ch = 0; ch < NCH; ch++) begin
                wr({4'(ch), 4'h0}, $urandom_range(0, 45));
                wr({4'(ch), 4'h1}, $urandom_range(0, 12));
                wr({4'(ch), 4'h2}, $urandom);
            end
            wr(8'hF1, $urandom_range(0, 3));
            wr(8'hF2, $urandom_range(0, 15));
            wr(8'hF3, $urandom_range(0, 3));
            wr({4'($urandom_range(4, 14)), 4'($urandom_range(0, 3))}, $urandom);
            run = 1'b1;
            len = int'($urandom_range(30, 150));
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 9) == 0)
                    wr({4'($urandom_range(0, 4)), 4'($urandom_range(0, 3))}, $urandom_range(0, 45));
                else
                    tick();
            end
            run = 1'b0;
            wait_idle(200);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pulse_seq_multi.md
PULSE_SEQ_MULTI -- requirements
Module: pulse_seq_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, number of pulse output channels (1..8).
REQ-002 SHALL have parameter CW, default 32, width of all timing counters and registers, in clk cycles.
REQ-003 SHALL have parameter SYNC_W, default 4, sync pulse length in clk cycles (1..255).
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-005 SHALL have port resetn, input, 1, synchronous active-high reset (asserted = 1).
REQ-006 SHALL have port cmd_valid, input, 1, command write strobe.
REQ-007 SHALL have port cmd_ready, output, 1, command accept; write occurs when cmd_valid & cmd_ready.
REQ-008 SHALL have port cmd_addr, input, 8, register select: [7:4] channel (0xF = global), [3:0] field.
REQ-009 SHALL have port cmd_data, input, CW, register write data.
REQ-010 SHALL have port run, input, 1, level; high starts or continues sequencing.
REQ-011 SHALL have port sync, output, 1, high for the first SYNC_W cycles of each period.
REQ-012 SHALL have port pulse, output, NCH, per-channel pulse outputs.
REQ-013 SHALL have port busy, output, 1, high while the FSM is not IDLE.
REQ-014 SHALL have port seq_done, output, 1, one-cycle strobe when a finite shot sequence completes.

Function
REQ-015 SHALL provide channel registers: field 0 delay, field 1 width, field 2 enable (bit 0); global registers: 0xF0 period, 0xF1 cpmg_n, 0xF2 cpmg_spacing, 0xF3 shots; writes to other addresses or channels >= NCH SHALL be ignored.
REQ-016 SHALL hold cmd_ready = 1 in every cycle except reset cycles.
REQ-017 SHALL write accepted commands into shadow registers in the accept cycle; active registers SHALL load from shadow in IDLE and on the cycle the period counter wraps to 0.
REQ-018 SHALL implement FSM IDLE -> RUN when run = 1; RUN -> IDLE at period end when run = 0 or shot count reached; no period is truncated.
REQ-019 SHALL, in RUN, count cnt from 0 to period-1 then wrap; period values < 2 SHALL be treated as 2.
REQ-020 SHALL drive pulse[i] registered, high when enable[i] and delay[i] <= cnt < delay[i]+width[i]; sum computed in CW+1 bits; no wrap past period end.
REQ-021 SHALL produce no pulse for width 0 or delay >= period.
REQ-022 SHALL drive sync high when cnt < SYNC_W, in RUN only; all outputs are registered with one cycle latency from cnt.
REQ-023 SHALL, with shots = 0, run continuously; with shots = N, run exactly N periods, then pulse seq_done for one cycle on the IDLE-entry cycle and return to IDLE even if run stays high; a new sequence requires run low for at least one cycle.
REQ-024 SHALL keep pulse, sync low and cnt = 0 in IDLE.

Reset
REQ-025 SHALL, on resetn = 1, clear all shadow and active registers, cnt, and the shot counter; enter IDLE; drive pulse = 0, sync = 0, busy = 0, seq_done = 0, cmd_ready = 0.
REQ-026 SHALL let reset mid-period abort immediately, without completing the period or emitting seq_done.

Configuration
REQ-027 SHALL, with macro PULSE_SEQ_CPMG_EN defined, OR onto pulse[0] an echo train: for k = 1..cpmg_n, high when delay[0]+k*cpmg_spacing <= cnt < that + 2*width[0]; terms in CW+1 bits; trains beyond period end truncated.
REQ-028 SHALL, without PULSE_SEQ_CPMG_EN, omit the echo logic; writes to 0xF1/0xF2 accepted but without effect.

Verification
REQ-029 SHALL cover: period=100, ch0 delay=10 width=5 enable, run=1 -> pulse[0] high cnt 10..14 each period; sync high cnt 0..3.
REQ-030 SHALL cover: shots=3, run held high -> exactly 3 periods, seq_done single-cycle strobe, busy low after, no restart until run toggles.
REQ-031 SHALL cover: ch1 width changed 5->20 at cnt=50 of period 100 -> current period unchanged, new width from next period.
REQ-032 SHALL cover: delay=90 width=20 period=100 -> pulse high cnt 90..99 only; width=0 -> never high.
REQ-033 SHALL cover: PULSE_SEQ_CPMG_EN, delay=10 width=4 cpmg_n=2 spacing=20 -> pulse[0] high 10..13, 30..37, 50..57.
REQ-034 SHALL cover: resetn asserted at cnt=40 -> next cycle all outputs 0, busy 0, no seq_done; registers read back as zero via pulse-free run.
